// File: rtl/wash_cycle_controller.sv
// Top-level washing machine sequencer: steps FILL/WASH/RINSE/SPIN phases by counting
// one-minute ticks from an external timer and drives that timer's run/pause/stop control.
//
//   state    | meaning
//   IDLE     | waiting for Coin, timer stopped
//   FILL     | filling drum, FILL_MIN minutes
//   WASH     | wash agitation, WASH_MIN minutes (visited twice on double wash)
//   RINSE    | rinse, RINSE_MIN minutes (visited twice on double wash)
//   SPIN     | final spin, SPIN_MIN minutes, then WashDone and back to IDLE
module wash_cycle_controller #(
  parameter logic [4:0] MINUTE_TICKS = 5'd20,
  parameter int         FILL_MIN     = 2,
  parameter int         WASH_MIN     = 5,
  parameter int         RINSE_MIN    = 2,
  parameter int         SPIN_MIN     = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Coin,
  input  logic       DoubleWash,
  input  logic       Pause,
  input  logic       TimerFlag,
  output logic [1:0] TimerMode,
  output logic [4:0] TimerStartPoint,
  output logic [2:0] State,
  output logic       WashDone
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_RINSE = 3'd3,
    ST_SPIN  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_PAUSE = 2'b01;
  localparam logic [1:0] MODE_STOP  = 2'b10;

  state_t     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic       done_q, done_d;
  logic [3:0] min_cnt_q, min_cnt_d;
  logic       second_pass_q, second_pass_d;
  logic       dw_latch_q, dw_latch_d;

  logic [3:0] last_min;
  logic       counted;
  logic       phase_end;

  // Flags only count while the timer is actually told to run.
  assign counted   = (state_q != ST_IDLE) && (mode_q == MODE_RUN) && TimerFlag;
  assign phase_end = counted && (min_cnt_q == last_min);

  always_comb begin
    last_min = 4'd0;
    case (state_q)
      ST_FILL:  last_min = 4'(FILL_MIN - 1);
      ST_WASH:  last_min = 4'(WASH_MIN - 1);
      ST_RINSE: last_min = 4'(RINSE_MIN - 1);
      ST_SPIN:  last_min = 4'(SPIN_MIN - 1);
      default:  last_min = 4'd0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    min_cnt_d     = min_cnt_q;
    second_pass_d = second_pass_q;
    dw_latch_d    = dw_latch_q;
    done_d        = 1'b0;

    if (state_q == ST_IDLE) begin
      if (Coin) begin
        state_d       = ST_FILL;
        dw_latch_d    = DoubleWash;
        second_pass_d = 1'b0;
        min_cnt_d     = 4'd0;
      end
    end else if (phase_end) begin
      min_cnt_d = 4'd0;
      case (state_q)
        ST_FILL:  state_d = ST_WASH;
        ST_WASH:  state_d = ST_RINSE;
        ST_RINSE: begin
          if (dw_latch_q && !second_pass_q) begin
            state_d       = ST_WASH;
            second_pass_d = 1'b1;
          end else begin
            state_d = ST_SPIN;
          end
        end
        ST_SPIN: begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
        default:  state_d = ST_IDLE;
      endcase
    end else if (counted) begin
      min_cnt_d = min_cnt_q + 4'd1;
    end

    if (state_d == ST_IDLE) begin
      mode_d = MODE_STOP;
    end else if (Pause) begin
      mode_d = MODE_PAUSE;
    end else begin
      mode_d = MODE_RUN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      mode_q        <= MODE_STOP;
      done_q        <= 1'b0;
      min_cnt_q     <= 4'd0;
      second_pass_q <= 1'b0;
      dw_latch_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      done_q        <= done_d;
      min_cnt_q     <= min_cnt_d;
      second_pass_q <= second_pass_d;
      dw_latch_q    <= dw_latch_d;
    end
  end

  assign State           = state_q;
  assign TimerMode       = mode_q;
  assign WashDone        = done_q;
  assign TimerStartPoint = MINUTE_TICKS;

endmodule

// File: tb/tb_wash_cycle_controller.sv
// Scoreboard bench for wash_cycle_controller: a phase-list reference model predicts each
// State/WashDone event; a negedge monitor pops and compares whenever the DUT's outputs change.
module tb_wash_cycle_controller;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Coin = 1'b0;
  logic       DoubleWash = 1'b0;
  logic       Pause = 1'b0;
  logic       TimerFlag = 1'b0;
  logic [1:0] TimerMode;
  logic [4:0] TimerStartPoint;
  logic [2:0] State;
  logic       WashDone;

  wash_cycle_controller dut (
    .CLK             (CLK),
    .RST             (RST),
    .Coin            (Coin),
    .DoubleWash      (DoubleWash),
    .Pause           (Pause),
    .TimerFlag       (TimerFlag),
    .TimerMode       (TimerMode),
    .TimerStartPoint (TimerStartPoint),
    .State           (State),
    .WashDone        (WashDone)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int st;
    int done;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;

  // reference model: list of phases still to run, minutes done in current phase
  int  m_phases[$];
  int  m_idx = 0;
  int  m_min = 0;
  bit  m_active = 1'b0;
  bit  prev_pause = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dur_of(input int st);
    case (st)
      1: return 2;
      2: return 5;
      3: return 2;
      4: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic ev_t mk(input int st, input int done);
    ev_t e;
    e.st = st;
    e.done = done;
    return e;
  endfunction

  // one clock: drive inputs, advance the model, check TimerMode after the edge
  task automatic step(input bit c, input bit dw, input bit p, input bit f);
    int exp_mode;
    Coin = c;
    DoubleWash = dw;
    Pause = p;
    TimerFlag = f;
    if (!m_active) begin
      if (c) begin
        m_phases = {1, 2, 3};
        if (dw) begin
          m_phases.push_back(2);
          m_phases.push_back(3);
        end
        m_phases.push_back(4);
        m_idx = 0;
        m_min = 0;
        m_active = 1'b1;
        exp_q.push_back(mk(1, 0));
      end
    end else if (f && !prev_pause) begin
      m_min++;
      if (m_min == dur_of(m_phases[m_idx])) begin
        m_min = 0;
        m_idx++;
        if (m_idx == m_phases.size()) begin
          m_active = 1'b0;
          exp_q.push_back(mk(0, 1));
        end else begin
          exp_q.push_back(mk(m_phases[m_idx], 0));
        end
      end
    end
    exp_mode = !m_active ? 2 : (p ? 1 : 0);
    @(posedge CLK);
    #1;
    chk("timer_mode", int'(TimerMode), exp_mode);
    prev_pause = p;
  endtask

  task automatic async_reset(input bit p);
    @(negedge CLK);
    #2;
    Coin = 1'b0;
    TimerFlag = 1'b0;
    Pause = p;
    RST = 1'b1;
    if (m_active) exp_q.push_back(mk(0, 0));
    m_active = 1'b0;
    #1;
    chk("rst_state", int'(State), 0);
    chk("rst_mode", int'(TimerMode), 2);
    chk("rst_done", int'(WashDone), 0);
    chk("rst_start_point", int'(TimerStartPoint), 20);
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    prev_pause = p;
  endtask

  // runs n flags spaced every 5 cycles; coin_between drives Coin/DoubleWash on gap cycles
  task automatic flags(input int n, input bit coin_between, input bit p);
    for (int k = 0; k < n; k++) begin
      for (int g = 0; g < 4; g++) step(coin_between && (k < n - 1), coin_between, p, 1'b0);
      step(1'b0, 1'b0, p, 1'b1);
    end
  endtask

  // monitor: every visible output event must match the next scoreboard entry
  logic [2:0] prev_st = 3'd0;
  ev_t        mon_e;
  always @(negedge CLK) begin
    if (State != prev_st || WashDone) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: state=%0d done=%0d expected no event at %0t",
                 State, WashDone, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("state_seq", int'(State), mon_e.st);
        chk("wash_done", int'(WashDone), mon_e.done);
      end
    end
    prev_st = State;
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("start_point", int'(TimerStartPoint), 20);

    // flags in IDLE are ignored
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("idle_state", int'(State), 0);
    async_reset(1'b0);

    // single wash
    step(1'b1, 1'b0, 1'b0, 1'b0);
    flags(10, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);

    // double wash
    step(1'b1, 1'b1, 1'b0, 1'b0);
    flags(17, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);

    // pause in WASH after flag #4
    step(1'b1, 1'b0, 1'b0, 1'b0);
    flags(4, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b1, (i % 5) == 2);
    chk("paused_state", int'(State), 2);
    flags(2, 1'b0, 1'b0);
    chk("after_pause_state", int'(State), 2);
    flags(4, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);

    // coins (with DoubleWash) during an active cycle are ignored; Coin+flag in IDLE accepted
    step(1'b1, 1'b0, 1'b0, 1'b1);
    flags(10, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);

    // reset mid-RINSE while paused, then a fresh cycle
    step(1'b1, 1'b1, 1'b0, 1'b0);
    flags(8, 1'b0, 1'b0);
    chk("in_rinse", int'(State), 3);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
    async_reset(1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    flags(10, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);

    // random traffic
    begin
      bit p = 1'b0;
      for (int i = 0; i < 2500; i++) begin
        if ($urandom_range(0, 19) == 0) p = ~p;
        if ($urandom_range(0, 599) == 0) async_reset(1'($urandom_range(0, 1)));
        step($urandom_range(0, 29) == 0, 1'($urandom_range(0, 1)), p,
             $urandom_range(0, 2) == 0);
      end
    end

    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wash_cycle_controller.md
Name: wash_cycle_controller

Overview:
Cycle sequencer that drives the one-minute timer's control interface (TimerMode, TimerStartPoint) and consumes its TimerFlag minute ticks. It steps the machine through FILL, WASH, RINSE and SPIN phases, counting minutes per phase. It handles start, pause, double-wash and completion, and is the top-level control FSM of the washing machine.

Parameters:
MINUTE_TICKS, 5'd20, value driven on TimerStartPoint (timer reload value per minute)
FILL_MIN, 2, FILL phase duration in minutes (1..15)
WASH_MIN, 5, WASH phase duration in minutes (1..15)
RINSE_MIN, 2, RINSE phase duration in minutes (1..15)
SPIN_MIN, 1, SPIN phase duration in minutes (1..15)

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  asynchronous, active-high reset
Coin  input  1  start request pulse; honoured only in IDLE
DoubleWash  input  1  sampled with an accepted Coin; selects a second WASH+RINSE pass
Pause  input  1  level; while high, an active phase is frozen
TimerFlag  input  1  one-cycle minute-complete tick from the timer
TimerMode  output  2  timer control: RUN=2'b00, PAUSE=2'b01, STOP=2'b10 (2'b11 never driven)
TimerStartPoint  output  5  constant MINUTE_TICKS
State  output  3  IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4
WashDone  output  1  one-cycle pulse when a cycle completes

Behaviour:
- One clock (CLK); reset is asynchronous and active-high (RST).
- Reset values: State=IDLE, TimerMode=STOP, WashDone=0, MinuteCount=0, SecondPass=0, DoubleWashLatch=0. TimerStartPoint=MINUTE_TICKS at all times, including during reset.
- Assertion of RST in any state, mid-phase or paused, returns to reset values immediately. After deassertion, the block waits in IDLE for a new Coin.
- State, TimerMode, WashDone and the internal 4-bit MinuteCount are registered. No combinational path runs from inputs to outputs.
- TimerMode register, next value:
  - STOP when the next State is IDLE.
  - PAUSE when the next State is active and Pause=1.
  - RUN otherwise.
  - Pause therefore takes effect on TimerMode one cycle after sampling.
- Minute counting: a TimerFlag counts only in a cycle where State is active and the TimerMode output equals RUN. Flags in any other cycle are ignored: IDLE, TimerMode=PAUSE, or TimerMode=STOP.
- Phase completion: a counted flag with MinuteCount == DUR-1 (DUR = duration of the current phase) ends the phase. On the next edge, State advances and MinuteCount clears to 0. Otherwise a counted flag increments MinuteCount.
- Transitions:
  - IDLE -> FILL on Coin=1. DoubleWash is latched on the same edge and SecondPass is cleared.
  - FILL -> WASH on phase completion.
  - WASH -> RINSE on phase completion.
  - RINSE -> WASH if DoubleWashLatch=1 and SecondPass=0, and SecondPass is set. Otherwise RINSE -> SPIN.
  - SPIN -> IDLE. WashDone=1 for exactly that one cycle; TimerMode becomes STOP.
- Coin in any non-IDLE state is ignored, and DoubleWash is not re-sampled.
- Coin and a TimerFlag together in IDLE: the Coin is accepted and the flag is ignored.
- Pause in IDLE has no effect, so TimerMode stays STOP.
- Pause held across a phase boundary: the boundary cannot occur, because flags are ignored while paused.
- Release of Pause: TimerMode returns to RUN on the following edge. MinuteCount resumes from its frozen value.
- Total minutes per cycle:
  - Single wash: FILL_MIN+WASH_MIN+RINSE_MIN+SPIN_MIN, which is 10 with the defaults.
  - Double wash: adds WASH_MIN+RINSE_MIN, which is 17 with the defaults.

Test Plan:
1. Reset/idle: assert RST mid-simulation for 3 cycles -> State=0, TimerMode=2'b10, WashDone=0, TimerStartPoint=MINUTE_TICKS; TimerFlag pulses in IDLE leave State=0.
2. Single wash: Coin=1, DoubleWash=0, then one TimerFlag every 5 cycles -> State sequence 1,2,3,4,0, changing after flags #2, #7, #9 and #10 respectively; WashDone pulses once, one cycle wide; TimerMode=RUN throughout the active phases.
3. Double wash: Coin=1 with DoubleWash=1 -> sequence 1,2,3,2,3,4,0; exactly 17 counted flags to reach IDLE; single WashDone pulse.
4. Pause in WASH: after flag #4 of the cycle, raise Pause for 30 cycles while still pulsing TimerFlag -> TimerMode=2'b01 from the next edge; State and MinuteCount unchanged; after release, 3 more counted flags are needed to leave WASH.
5. Ignored inputs: Coin pulses during FILL and RINSE, and Coin together with DoubleWash=1 during WASH -> no restart, no change in pass count; State sequence is identical to scenario 2.
6. Reset mid-cycle: assert RST asynchronously (not edge-aligned) during RINSE with Pause=1 -> outputs reach reset values before the next clock edge; a subsequent Coin starts a fresh FILL with MinuteCount=0.
